// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types and limits for the IO bus arbiter.
//   arb_state_t  - arbiter FSM states (IDLE, ISSUE, RESP)
//   MAX_MASTERS  - largest requester count the arbiter is built for
package io_arb_pkg;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/io_rr_pick.sv
// io_rr_pick: combinational round-robin selector.
// Scans the request vector starting one position above the last grant and
// wrapping around, so the most recently served requester has lowest priority.
//   i_req        [N-1:0]      request vector
//   i_last_grant [IDX_W-1:0]  index granted last time
//   o_valid                   at least one request pending
//   o_winner     [IDX_W-1:0]  selected index (0 when o_valid is low)
module io_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_winner
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    // Offset 1 first, offset N (the last grant itself) last.
    for (int i = 1; i <= N; i++) begin
      w_idx = IDX_W'((int'(i_last_grant) + i) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the single-cycle IO bus among NUM_MASTERS requesters.
// One bus transaction per grant: IDLE latches the winner's command, ISSUE
// drives the bus strobe for one cycle and captures read data, RESP returns a
// one-cycle one-hot ack with the captured data.
//   clk, reset                      clock, async active-high reset
//   m_req/m_wr/m_rd [NUM_MASTERS]   per-master request and command strobes
//   m_addr/m_wr_data [NUM_MASTERS]  per-master address and write data
//   m_ack [NUM_MASTERS]             one-hot completion pulse
//   m_rd_data                       read data, valid only with m_ack
//   bus_cs/wr/rd/addr/wr_data       registered IO bus outputs
//   bus_rd_data                     IO bus read data (combinational from slot)
//   busy                            high in ISSUE and RESP
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_wr,
  input  logic [NUM_MASTERS-1:0] m_rd,
  input  logic [ADDR_W-1:0]      m_addr    [NUM_MASTERS],
  input  logic [DATA_W-1:0]      m_wr_data [NUM_MASTERS],
  output logic [NUM_MASTERS-1:0] m_ack,
  output logic [DATA_W-1:0]      m_rd_data,
  output logic                   bus_cs,
  output logic                   bus_wr,
  output logic                   bus_rd,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W-1:0]      bus_wr_data,
  input  logic [DATA_W-1:0]      bus_rd_data,
  output logic                   busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_winner;
  logic             w_valid;

  io_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req        (m_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_next = ISSUE;
      ISSUE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The bus output registers double as the command latch; m_rd_data is the
  // read-data register and only ever holds non-zero data during RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= IDX_W'(NUM_MASTERS - 1);
      r_idx        <= '0;
      bus_cs       <= 1'b0;
      bus_wr       <= 1'b0;
      bus_rd       <= 1'b0;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
      m_ack        <= '0;
      m_rd_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_idx       <= w_winner;
            bus_cs      <= 1'b1;
            bus_wr      <= m_wr[w_winner];
            // wr and rd together is a write; never strobe both.
            bus_rd      <= m_rd[w_winner] & ~m_wr[w_winner];
            bus_addr    <= m_addr[w_winner];
            bus_wr_data <= m_wr_data[w_winner];
          end
        end
        ISSUE: begin
          bus_cs    <= 1'b0;
          bus_wr    <= 1'b0;
          bus_rd    <= 1'b0;
          m_ack     <= NUM_MASTERS'(1) << r_idx;
          m_rd_data <= bus_rd ? bus_rd_data : '0;
        end
        RESP: begin
          m_ack        <= '0;
          m_rd_data    <= '0;
          r_last_grant <= r_idx;
          bus_addr     <= '0;
          bus_wr_data  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [1:0]  m_rd;
  logic [31:0] m_addr    [2];
  logic [31:0] m_wr_data [2];
  logic [1:0]  m_ack;
  logic [31:0] m_rd_data;
  logic        bus_cs;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        busy;

  int n_tests;
  int n_fail;

  io_bus_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_W      (32),
    .DATA_W      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req       (m_req),
    .m_wr        (m_wr),
    .m_rd        (m_rd),
    .m_addr      (m_addr),
    .m_wr_data   (m_wr_data),
    .m_ack       (m_ack),
    .m_rd_data   (m_rd_data),
    .bus_cs      (bus_cs),
    .bus_wr      (bus_wr),
    .bus_rd      (bus_rd),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int m, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wdata);
    m_wr[m]      = wr;
    m_rd[m]      = rd;
    m_addr[m]    = addr;
    m_wr_data[m] = wdata;
    m_req[m]     = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated transaction; called aligned to a negedge with DUT in IDLE.
  task automatic run_txn(input string tag, input int m, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_wr, input logic exp_rd,
                         input logic [1:0] exp_ack, input logic [31:0] exp_rdata);
    set_cmd(m, wr, rd, addr, wdata);
    @(negedge clk);
    check_eq({tag, ".cs"},    bus_cs, 1'b1);
    check_eq({tag, ".wr"},    bus_wr, exp_wr);
    check_eq({tag, ".rd"},    bus_rd, exp_rd);
    check_eq({tag, ".addr"},  bus_addr, addr);
    check_eq({tag, ".wdata"}, bus_wr_data, wdata);
    check_eq({tag, ".busy"},  busy, 1'b1);
    check_eq({tag, ".noack"}, m_ack, 2'b00);
    @(negedge clk);
    check_eq({tag, ".ack"},    m_ack, exp_ack);
    check_eq({tag, ".rdata"},  m_rd_data, exp_rdata);
    check_eq({tag, ".cs_off"}, bus_cs, 1'b0);
    check_eq({tag, ".rd_off"}, bus_rd, 1'b0);
    check_eq({tag, ".hold"},   bus_addr, addr);
    m_req[m] = 1'b0;
    @(negedge clk);
    check_eq({tag, ".ack_off"},   m_ack, 2'b00);
    check_eq({tag, ".rdata_off"}, m_rd_data, 32'h0);
    check_eq({tag, ".idle"},      busy, 1'b0);
    check_eq({tag, ".addr_idle"}, bus_addr, 32'h0);
  endtask

  logic [1:0]  exp_ack_tbl [12];
  logic [31:0] exp_addr_tbl [12];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    m_req   = '0;
    m_wr    = '0;
    m_rd    = '0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i]    = '0;
      m_wr_data[i] = '0;
    end
    bus_rd_data = 32'hDEAD_BEEF;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst.cs",    bus_cs, 1'b0);
    check_eq("rst.ack",   m_ack, 2'b00);
    check_eq("rst.rdata", m_rd_data, 32'h0);
    check_eq("rst.busy",  busy, 1'b0);
    check_eq("rst.addr",  bus_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle.cs", bus_cs, 1'b0);

    // Single read by master 0, single write by master 1.
    run_txn("rd0", 0, 1'b0, 1'b1, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 2'b01, 32'hDEAD_BEEF);
    run_txn("wr1", 1, 1'b1, 1'b0, 32'h0000_0088, 32'h0000_00A5, 1'b1, 1'b0, 2'b10, 32'h0);
    // Boundary commands.
    bus_rd_data = 32'h1234_5678;
    run_txn("wrrd0", 0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0077, 1'b1, 1'b0, 2'b01, 32'h0);
    run_txn("nop1",  1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0011, 1'b0, 1'b0, 2'b10, 32'h0);

    // Sticky request: master 0 keeps req high, master 1 idle.
    set_cmd(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check_eq("stk.cs1", bus_cs, 1'b1);
    @(negedge clk);
    check_eq("stk.ack1",   m_ack, 2'b01);
    check_eq("stk.rdata1", m_rd_data, 32'h1234_5678);
    @(negedge clk);
    check_eq("stk.gap", m_ack, 2'b00);
    @(negedge clk);
    check_eq("stk.cs2", bus_cs, 1'b1);
    @(negedge clk);
    check_eq("stk.ack2", m_ack, 2'b01);
    m_req = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("stk.done", bus_cs, 1'b0);

    // Reset during ISSUE; last grant was master 0, so without the reset of
    // last_grant master 1 would win the next contention.
    set_cmd(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0055);
    @(posedge clk);
    #2;
    check_eq("rsti.cs_pre", bus_cs, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("rsti.cs",   bus_cs, 1'b0);
    check_eq("rsti.wr",   bus_wr, 1'b0);
    check_eq("rsti.addr", bus_addr, 32'h0);
    check_eq("rsti.busy", busy, 1'b0);
    @(negedge clk);
    check_eq("rsti.noack", m_ack, 2'b00);
    reset = 1'b0;
    set_cmd(1, 1'b0, 1'b1, 32'h0000_0030, 32'h0);
    @(negedge clk);
    check_eq("rsti.re_addr", bus_addr, 32'h0000_0020);
    @(negedge clk);
    check_eq("rsti.re_ack", m_ack, 2'b01);
    m_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rsti.m1_addr", bus_addr, 32'h0000_0030);
    @(negedge clk);
    check_eq("rsti.m1_ack", m_ack, 2'b10);
    m_req = '0;
    @(negedge clk);

    // Contention after reset: grant order 0,1,0,1 with acks 3 cycles apart.
    do_reset();
    bus_rd_data = 32'hCAFE_0001;
    for (int c = 0; c < 12; c++) begin
      exp_ack_tbl[c]  = 2'b00;
      exp_addr_tbl[c] = 32'h0;
    end
    exp_addr_tbl[0] = 32'h0000_0100; exp_ack_tbl[1]  = 2'b01;
    exp_addr_tbl[3] = 32'h0000_0200; exp_ack_tbl[4]  = 2'b10;
    exp_addr_tbl[6] = 32'h0000_0100; exp_ack_tbl[7]  = 2'b01;
    exp_addr_tbl[9] = 32'h0000_0200; exp_ack_tbl[10] = 2'b10;
    set_cmd(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    set_cmd(1, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_eq($sformatf("cont.ack%0d", c), m_ack, exp_ack_tbl[c]);
      if (c % 3 == 0)
        check_eq($sformatf("cont.addr%0d", c), bus_addr, exp_addr_tbl[c]);
      if (c % 3 == 1)
        check_eq($sformatf("cont.rdata%0d", c), m_rd_data, 32'hCAFE_0001);
    end
    m_req = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("cont.end", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single IO bus (bus_cs/bus_wr/bus_rd/bus_addr/bus_wr_data/bus_rd_data) feeding the IO controller and its slots (UART, matrix multiplier, ...) among NUM_MASTERS requesters (CPU load/store unit, future DMA engine).
- Arbitrates round-robin, issues exactly one single-cycle bus transaction per grant, registers the read data and returns a one-cycle ack to the winner.
- Sits between the masters and io_top.

Parameters:
- NUM_MASTERS, 2, number of requesters; range 2..8.
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- m_req  input  NUM_MASTERS  per-master request; held with its command until ack.
- m_wr  input  NUM_MASTERS  per-master write strobe.
- m_rd  input  NUM_MASTERS  per-master read strobe.
- m_addr  input  ADDR_W x NUM_MASTERS (unpacked)  per-master address.
- m_wr_data  input  DATA_W x NUM_MASTERS (unpacked)  per-master write data.
- m_ack  output  NUM_MASTERS  one-hot, one-cycle completion pulse.
- m_rd_data  output  DATA_W  read data, shared by all masters; valid only with m_ack.
- bus_cs  output  1  IO bus chip select.
- bus_wr  output  1  IO bus write.
- bus_rd  output  1  IO bus read.
- bus_addr  output  ADDR_W  IO bus address.
- bus_wr_data  output  DATA_W  IO bus write data.
- bus_rd_data  input  DATA_W  IO bus read data; combinational from the IO controller in the issue cycle.
- busy  output  1  high in ISSUE and RESP.

Behaviour:
- The clock is clk; reset is asynchronous and active-high. On reset: state = IDLE, all outputs 0, last_grant = NUM_MASTERS-1 (master 0 has first priority), and the command and rdata registers are cleared.
- A reset mid-transaction aborts it: no ack is generated, and masters must re-request.
- FSM states: IDLE, ISSUE, RESP. All bus outputs are registers.
- IDLE:
  - If any m_req is high, winner = first set bit scanning from (last_grant+1) mod NUM_MASTERS upward with wrap.
  - Latch the winner's index, wr, rd, addr and wr_data, then go to ISSUE.
  - If no request is pending, stay in IDLE with the bus outputs at 0.
- ISSUE (exactly 1 cycle):
  - bus_cs = 1, bus_wr/bus_rd/bus_addr/bus_wr_data driven from the latched command.
  - If the latched rd = 1, capture bus_rd_data into rdata_q at the end of this cycle; otherwise rdata_q = 0.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - bus_cs/wr/rd = 0, bus_addr and bus_wr_data hold their last values.
  - m_ack[winner] = 1 and m_rd_data = rdata_q.
  - last_grant = winner, then go to IDLE.
- Latency: request seen in IDLE at cycle t → bus strobe at t+1 → ack at t+2. Minimum 3 cycles per transaction; back-to-back requests from different masters are granted every 3 cycles.
- Master rule: req must be deasserted or changed on the edge that samples ack. A req still high in the following IDLE is treated as a new transaction.
- m_rd_data is 0 whenever no ack is asserted.
- Command encoding:
  - wr = 1 and rd = 1: treated as a write (bus_rd forced to 0).
  - wr = 0 and rd = 0: bus_cs pulses with no strobe; ack is still returned with rd_data = 0.
- Requests that change during ISSUE or RESP are ignored, because the command was already latched.
- Fairness: a master that keeps requesting waits at most NUM_MASTERS-1 transactions.
- m_ack is always one-hot or zero, never multi-bit.

Decomposition:
- Package io_arb_pkg: state enum typedef (IDLE, ISSUE, RESP); a constant MAX_MASTERS = 8.
- Sub-module io_rr_pick: purely combinational round-robin select (inputs req vector and last_grant; outputs valid and winner index). It is reused later for the interrupt controller.
- The FSM, command latch and rdata register stay in io_bus_arbiter.

Test Plan:
- Single read: master 0 reads addr 0x0000_0004 while the slot model returns 0xDEAD_BEEF. Required: bus_rd = 1 and bus_cs = 1 for exactly one cycle at t+1; m_ack = 2'b01 at t+2 with m_rd_data = 0xDEAD_BEEF; m_rd_data = 0 on the next cycle.
- Single write: master 1 writes 0x0000_00A5 to 0x0000_0088. Required: bus_wr = 1 with that address and data for one cycle; m_ack = 2'b10 at t+2 with m_rd_data = 0.
- Contention: both masters request continuously after reset. Required grant order 0, 1, 0, 1; acks 3 cycles apart; never both ack bits high.
- Boundary commands: wr = rd = 1 → bus_wr = 1, bus_rd = 0. wr = rd = 0 → bus_cs pulse only, ack returned, rd_data = 0.
- Reset during ISSUE (assert reset mid-cycle) → outputs go to 0 immediately, no ack, state IDLE. Master 0 re-requests → served first.
- Sticky request: master 0 keeps req high after its ack with master 1 idle → a second transaction is issued (ack again 3 cycles later).
